// File: rtl/vote_pkg.sv
// rtl/vote_pkg.sv - shared state encoding and default sizing for the ballot collector
package vote_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam int unsigned DEF_N_VOTERS = 4;
  localparam int unsigned DEF_ID_W     = 2;
  localparam int unsigned DEF_CNT_W    = 3;

endpackage

// File: rtl/vote_decide.sv
// rtl/vote_decide.sv - combinational verdict from final yes/no tallies
module vote_decide
  import vote_pkg::*;
#(
  parameter int unsigned N_VOTERS = DEF_N_VOTERS,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic [CNT_W-1:0] yes_count,
  input  logic [CNT_W-1:0] no_count,
  output logic             vote_result,
  output logic             majority,
  output logic             tie
);

  localparam logic [CNT_W-1:0] HALF = CNT_W'(N_VOTERS / 2);
  localparam bit               EVEN = (N_VOTERS % 2) == 0;

  logic yes_wins;
  logic no_wins;

  always_comb begin
    yes_wins    = yes_count > HALF;
    no_wins     = no_count > HALF;
    vote_result = yes_wins;
    majority    = yes_wins | no_wins;
    // An odd electorate can never split evenly once every ballot is in.
    tie         = EVEN && (yes_count == no_count);
  end

endmodule

// File: rtl/vote_tally_fsm.sv
// rtl/vote_tally_fsm.sv - serial ballot collector with duplicate rejection and registered verdict
module vote_tally_fsm
  import vote_pkg::*;
#(
  parameter int unsigned N_VOTERS = DEF_N_VOTERS,
  parameter int unsigned ID_W     = DEF_ID_W,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ballot_valid,
  output logic             ballot_ready,
  input  logic             ballot_yes,
  input  logic [ID_W-1:0]  ballot_id,
  output logic             ballot_err,
  output logic [CNT_W-1:0] yes_count,
  output logic             result_valid,
  output logic             vote_result,
  output logic             majority,
  output logic             tie
);

  localparam int unsigned      ID_SPACE = 1 << ID_W;
  localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N_VOTERS);
  // Bit i set when voter id i belongs to this electorate; avoids a width-limited compare.
  localparam logic [ID_SPACE-1:0] ID_OK = ID_SPACE'((64'd1 << N_VOTERS) - 64'd1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      yes_q, yes_d;
  logic [CNT_W-1:0]      no_q, no_d;
  logic [CNT_W-1:0]      acc_q, acc_d;
  logic [ID_SPACE-1:0]   voted_q, voted_d;
  logic                  err_q, err_d;
  logic                  vr_q, vr_d;
  logic                  maj_q, maj_d;
  logic                  tie_q, tie_d;

  logic                  handshake;
  logic                  ballot_bad;
  logic                  finish;
  logic                  dec_vr;
  logic                  dec_maj;
  logic                  dec_tie;

  assign ballot_ready = (state_q == ST_COLLECT);
  assign result_valid = (state_q == ST_DONE);
  assign handshake    = ballot_valid & ballot_ready;
  assign ballot_bad   = ~ID_OK[ballot_id] | voted_q[ballot_id];

  always_comb begin
    state_d = state_q;
    yes_d   = yes_q;
    no_d    = no_q;
    acc_d   = acc_q;
    voted_d = voted_q;
    err_d   = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_COLLECT;
          yes_d   = '0;
          no_d    = '0;
          acc_d   = '0;
          voted_d = '0;
        end
      end
      ST_COLLECT: begin
        // Abort wins over any ballot presented in the same cycle.
        if (start) begin
          yes_d   = '0;
          no_d    = '0;
          acc_d   = '0;
          voted_d = '0;
        end else if (handshake) begin
          if (ballot_bad) begin
            err_d = 1'b1;
          end else begin
            voted_d[ballot_id] = 1'b1;
            if (ballot_yes) begin
              yes_d = yes_q + CNT_W'(1);
            end else begin
              no_d = no_q + CNT_W'(1);
            end
            acc_d = acc_q + CNT_W'(1);
            if (acc_d == N_CNT) begin
              state_d = ST_DONE;
              finish  = 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  vote_decide #(
    .N_VOTERS (N_VOTERS),
    .CNT_W    (CNT_W)
  ) u_decide (
    .yes_count   (yes_d),
    .no_count    (no_d),
    .vote_result (dec_vr),
    .majority    (dec_maj),
    .tie         (dec_tie)
  );

  // Verdict is captured from the final tallies on the edge that enters DONE.
  always_comb begin
    vr_d  = vr_q;
    maj_d = maj_q;
    tie_d = tie_q;
    if (finish) begin
      vr_d  = dec_vr;
      maj_d = dec_maj;
      tie_d = dec_tie;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      yes_q   <= '0;
      no_q    <= '0;
      acc_q   <= '0;
      voted_q <= '0;
      err_q   <= 1'b0;
      vr_q    <= 1'b0;
      maj_q   <= 1'b0;
      tie_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      yes_q   <= yes_d;
      no_q    <= no_d;
      acc_q   <= acc_d;
      voted_q <= voted_d;
      err_q   <= err_d;
      vr_q    <= vr_d;
      maj_q   <= maj_d;
      tie_q   <= tie_d;
    end
  end

  assign ballot_err  = err_q;
  assign yes_count   = yes_q;
  assign vote_result = vr_q;
  assign majority    = maj_q;
  assign tie         = tie_q;

endmodule

// File: tb/tb_vote_tally_fsm.sv
// tb/tb_vote_tally_fsm.sv - directed self-checking bench for the ballot collector
module tb_vote_tally_fsm;

  localparam int unsigned N_VOTERS = 4;
  localparam int unsigned ID_W     = 2;
  localparam int unsigned CNT_W    = 3;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             ballot_valid;
  logic             ballot_ready;
  logic             ballot_yes;
  logic [ID_W-1:0]  ballot_id;
  logic             ballot_err;
  logic [CNT_W-1:0] yes_count;
  logic             result_valid;
  logic             vote_result;
  logic             majority;
  logic             tie;

  int n_cmp = 0;
  int n_bad = 0;

  vote_tally_fsm #(
    .N_VOTERS (N_VOTERS),
    .ID_W     (ID_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .ballot_valid (ballot_valid),
    .ballot_ready (ballot_ready),
    .ballot_yes   (ballot_yes),
    .ballot_id    (ballot_id),
    .ballot_err   (ballot_err),
    .yes_count    (yes_count),
    .result_valid (result_valid),
    .vote_result  (vote_result),
    .majority     (majority),
    .tie          (tie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [ID_W-1:0] id, input logic y);
    ballot_valid = 1'b1;
    ballot_id    = id;
    ballot_yes   = y;
    tick();
    ballot_valid = 1'b0;
  endtask

  // Sends voters 0..3 with yes bit pat[i] and checks the DONE cycle against hand-derived rules.
  task automatic send_all(input string tag, input logic [3:0] pat);
    int y;
    int n;
    y = 0;
    for (int i = 0; i < 4; i++) begin
      check({tag, " rv_before"}, result_valid, 0);
      send(i[ID_W-1:0], pat[i]);
      if (pat[i]) y++;
    end
    n = 4 - y;
    check({tag, " rv"}, result_valid, 1);
    check({tag, " ready_done"}, ballot_ready, 0);
    check({tag, " yes"}, yes_count, y);
    check({tag, " vr"}, vote_result, (y > 2) ? 1 : 0);
    check({tag, " maj"}, majority, (y > 2 || n > 2) ? 1 : 0);
    check({tag, " tie"}, tie, (y == n) ? 1 : 0);
  endtask

  task automatic round(input string tag, input logic [3:0] pat);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " ready"}, ballot_ready, 1);
    check({tag, " yes0"}, yes_count, 0);
    send_all(tag, pat);
    tick();
    check({tag, " rv_drop"}, result_valid, 0);
    check({tag, " idle_ready"}, ballot_ready, 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    ballot_valid = 1'b0;
    ballot_yes   = 1'b0;
    ballot_id    = '0;
    #2;
    check("rst ready", ballot_ready, 0);
    check("rst err", ballot_err, 0);
    check("rst yes", yes_count, 0);
    check("rst rv", result_valid, 0);
    check("rst vr", vote_result, 0);
    check("rst maj", majority, 0);
    check("rst tie", tie, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Yes,yes,no,yes -> yes majority
    round("r1", 4'b1011);
    check("r1 hold vr", vote_result, 1);

    // Split vote -> tie
    round("r2", 4'b0101);
    check("r2 hold tie", tie, 1);

    // Duplicate id 0 is rejected once
    start = 1'b1;
    tick();
    start = 1'b0;
    send(2'd0, 1'b0);
    check("dup err_none", ballot_err, 0);
    send(2'd0, 1'b1);
    check("dup err", ballot_err, 1);
    check("dup yes", yes_count, 0);
    send(2'd1, 1'b0);
    check("dup err_clear", ballot_err, 0);
    send(2'd2, 1'b0);
    check("dup rv_early", result_valid, 0);
    send(2'd3, 1'b0);
    check("dup rv", result_valid, 1);
    check("dup yes_end", yes_count, 0);
    check("dup vr", vote_result, 0);
    check("dup maj", majority, 1);
    check("dup tie", tie, 0);
    tick();

    // Abort with a simultaneous ballot, then a clean round
    start = 1'b1;
    tick();
    start = 1'b0;
    send(2'd0, 1'b1);
    send(2'd1, 1'b1);
    check("abort yes2", yes_count, 2);
    start        = 1'b1;
    ballot_valid = 1'b1;
    ballot_id    = 2'd2;
    ballot_yes   = 1'b1;
    tick();
    start        = 1'b0;
    ballot_valid = 1'b0;
    check("abort yes0", yes_count, 0);
    check("abort ready", ballot_ready, 1);
    check("abort err", ballot_err, 0);
    send_all("abort_round", 4'b1011);
    tick();

    // Asynchronous reset mid-round
    start = 1'b1;
    tick();
    start = 1'b0;
    send(2'd0, 1'b1);
    check("ar yes1", yes_count, 1);
    check("ar hold vr", vote_result, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar ready", ballot_ready, 0);
    check("ar yes", yes_count, 0);
    check("ar vr", vote_result, 0);
    check("ar maj", majority, 0);
    check("ar rv", result_valid, 0);
    #2;
    rst_n = 1'b1;
    ballot_valid = 1'b1;
    ballot_id    = 2'd1;
    ballot_yes   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle ready", ballot_ready, 0);
      check("idle err", ballot_err, 0);
      check("idle yes", yes_count, 0);
    end
    ballot_valid = 1'b0;

    // Every yes/no pattern as back-to-back full rounds
    for (int p = 0; p < 16; p++) begin
      round($sformatf("sweep%0d", p), p[3:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule

// File: doc/vote_tally_fsm.md
Name: vote_tally_fsm

Overview:
Sequential ballot collector and the receiving end of the voting interface. Voters submit ballots one at a time over a valid/ready handshake. The block rejects duplicate and out-of-range voters and counts yes votes. Once all N_VOTERS ballots are in, it publishes VoteResult / Majority / Tie as registered outputs with a one-cycle result strobe. It replaces the combinational 4-input voter where ballots arrive serially from a shared bus.

Parameters:
N_VOTERS, 4, number of ballots per round (2..16)
ID_W, 2, width of ballot_id; must satisfy 2**ID_W >= N_VOTERS
CNT_W, 3, width of tally counters; must satisfy 2**CNT_W > N_VOTERS

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin new round; clears tallies and voted map
ballot_valid  in  1  ballot present on ballot_yes/ballot_id
ballot_ready  out  1  block can accept a ballot this cycle
ballot_yes  in  1  1 = yes vote, 0 = no vote
ballot_id  in  ID_W  voter index 0..N_VOTERS-1
ballot_err  out  1  one-cycle pulse: handshaken ballot rejected (duplicate or id >= N_VOTERS)
yes_count  out  CNT_W  running count of accepted yes ballots
result_valid  out  1  one-cycle pulse: round complete, result outputs updated
vote_result  out  1  1 when yes_count > N_VOTERS/2 (strict yes majority)
majority  out  1  1 when either side has a strict majority (yes or no count > N_VOTERS/2)
tie  out  1  1 when yes_count == no_count (even N_VOTERS only; always 0 for odd)

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Values while rst_n=0: state=IDLE; ballot_ready, ballot_err, result_valid, vote_result, majority, tie = 0; yes_count, internal no_count, accepted count and voted bitmap = 0.
- State machine: IDLE, COLLECT, DONE, held in a registered state variable.
- IDLE:
  - ballot_ready=0.
  - start=1 -> COLLECT next cycle, clearing yes_count, no_count, accepted count and voted bitmap.
  - Result outputs keep the previous round's values.
- COLLECT:
  - ballot_ready=1 (Moore output, purely state-decoded).
  - A handshake is ballot_valid & ballot_ready at a rising edge.
  - If ballot_id >= N_VOTERS, or voted[ballot_id]=1: ballot is discarded, ballot_err=1 next cycle, counters unchanged.
  - Otherwise: set voted[ballot_id]; increment yes_count or no_count; increment accepted count.
  - When the accepted count reaches N_VOTERS on this edge -> DONE.
  - start=1 in COLLECT aborts the round: counters and bitmap cleared, stays in COLLECT, and any simultaneous ballot is dropped (start has priority).
- DONE (exactly one cycle):
  - ballot_ready=0; result_valid=1.
  - vote_result, majority and tie are registered on entry to DONE from the final tallies, so they are valid in the same cycle as result_valid.
  - Next state is IDLE.
  - start in DONE is ignored; it must be re-asserted in IDLE.
- Latency: result_valid asserts exactly 1 cycle after the edge that accepts the final valid ballot.
- Minimum round length: N_VOTERS + 2 cycles from start.
- Result outputs hold until the next round's DONE.
- yes_count is visible live throughout COLLECT and holds after DONE.
- Width and arithmetic rules:
  - Comparisons use CNT_W-bit unsigned values.
  - The threshold N_VOTERS/2 is integer division.
  - Counters cannot overflow, because accepted count ≤ N_VOTERS < 2**CNT_W.
- Back-to-back ballots: one per cycle accepted with no bubbles.
- ballot_valid in IDLE or DONE: no handshake; ballot is not consumed; no error.
- rst_n deasserted mid-round: immediate return to the reset values; the partial round is lost.

Decomposition:
- Shared package vote_pkg holds the state encoding (IDLE=2'd0, COLLECT=2'd1, DONE=2'd2) and the default N_VOTERS constant.
- Natural sub-module: vote_decide, purely combinational. It maps (yes_count, no_count) to (vote_result, majority, tie). It is reused by the existing combinational voter bench as a golden model.

Test Plan:
- Reset, then start, then ballots (id, yes) = (0,1), (1,1), (2,0), (3,1) on consecutive cycles -> yes_count ends at 3; result_valid pulses one cycle after the 4th ballot; vote_result=1, majority=1, tie=0.
- Ballots (0,1), (1,0), (2,1), (3,0) -> vote_result=0, majority=0, tie=1, yes_count=2.
- Ballots (0,0), (0,1) (duplicate), (1,0), (2,0), (3,0) -> ballot_err pulses once after the duplicate; yes_count stays 0; vote_result=0, majority=1, tie=0.
- start re-asserted after two accepted ballots, together with a valid ballot -> that ballot is dropped; counts reset to 0; a full 4-ballot round (3 yes) then yields vote_result=1 with no leftover from the aborted round.
- rst_n pulsed low asynchronously mid-round (between edges) -> all outputs 0 immediately; ballot_valid held high in IDLE afterwards -> ballot_ready=0, no error, no count change.
- Exhaustive sweep of all 16 yes/no patterns as full rounds -> outputs match vote_decide for every pattern, with a round-to-round interval of N_VOTERS+2 cycles.
